uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_tick_gen.sv | 51 +++++
 rtl/uart_rx_oversample.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state codes, baud_select encodings and the
// sample-tick divisor calculation.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  localparam logic [1:0] BAUD_1200  = 2'b00;
  localparam logic [1:0] BAUD_2400  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_PARITY    = 3'd3;
  localparam rx_state_t ST_STOP      = 3'd4;
  localparam rx_state_t ST_WAIT_IDLE = 3'd5;

  function automatic int unsigned baud_rate(input logic [1:0] sel);
    int unsigned rate;
    case (sel)
      BAUD_1200: rate = 1200;
      BAUD_2400: rate = 2400;
      BAUD_9600: rate = 9600;
      default:   rate = 19200;
    endcase
    return rate;
  endfunction

  // Rounded-to-nearest clock cycles per sample tick.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned oversample,
                                           input logic [1:0]  sel);
    int unsigned den;
    den = baud_rate(sel) * oversample;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Sample-tick generator: one-cycle tick every baud_div() clocks, phase reset by clear.
// Shared by the UART receiver and transmitter.
module uart_baud_tick_gen import uart_pkg::*; #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [1:0] baud_select,
  input  logic       clear,
  output logic       tick
);

  localparam int unsigned Div1200  = baud_div(CLK_HZ, OVERSAMPLE, BAUD_1200);
  localparam int unsigned Div2400  = baud_div(CLK_HZ, OVERSAMPLE, BAUD_2400);
  localparam int unsigned Div9600  = baud_div(CLK_HZ, OVERSAMPLE, BAUD_9600);
  localparam int unsigned Div19200 = baud_div(CLK_HZ, OVERSAMPLE, BAUD_19200);
  localparam int unsigned CntW     = (Div1200 > 1) ? $clog2(Div1200) : 1;

  logic [CntW-1:0] cnt_q, cnt_d, last_cnt;

  always_comb begin
    unique case (baud_select)
      BAUD_1200: last_cnt = CntW'(Div1200 - 1);
      BAUD_2400: last_cnt = CntW'(Div2400 - 1);
      BAUD_9600: last_cnt = CntW'(Div9600 - 1);
      default:   last_cnt = CntW'(Div19200 - 1);
    endcase
  end

  // >= keeps the counter bounded if the divisor shrinks while running.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q >= last_cnt) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 8 data bits LSB first, parity, one stop bit; each bit is
// the 2-of-3 vote of the samples around its middle.
module uart_rx_oversample import uart_pkg::*; #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [1:0] baud_select,
  input  logic       parity_type,
  input  logic       rx_in,
  output logic [7:0] rx_data_out,
  output logic       rx_data_ready,
  output logic       rx_busy,
  output logic       parity_error,
  output logic       framing_error
);

  localparam int unsigned     CntW     = $clog2(OVERSAMPLE + 1);
  localparam logic [CntW-1:0] TickLo   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] TickMid  = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] TickHi   = CntW'(OVERSAMPLE / 2 + 1);
  localparam logic [CntW-1:0] TickLast = CntW'(OVERSAMPLE);

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [1:0]      baud_q, baud_d;
  logic            parity_type_q, parity_type_d;
  logic [CntW-1:0] smp_cnt_q, smp_cnt_d, tick_num;
  logic [1:0]      votes_q, votes_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_rx_q, par_rx_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            tick, clear, fall, bit_val, at_sample, at_end, in_frame;

  uart_baud_tick_gen #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_gen (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .baud_select (baud_q),
    .clear       (clear),
    .tick        (tick)
  );

  assign fall      = rx_prev_q & ~rx_s2_q;
  assign tick_num  = smp_cnt_q + CntW'(1);
  assign at_sample = tick && (tick_num == TickHi);
  assign at_end    = tick && (tick_num == TickLast);
  assign in_frame  = (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE);
  // The third vote is the live sample taken at the decision tick.
  assign bit_val   = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s2_q) |
                     (votes_q[1] & rx_s2_q);

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    parity_type_d = parity_type_q;
    smp_cnt_d     = smp_cnt_q;
    votes_d       = votes_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    par_rx_d      = par_rx_q;
    data_d        = data_q;
    ready_d       = 1'b0;
    busy_d        = busy_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    clear         = 1'b0;

    if (tick && in_frame) begin
      smp_cnt_d = at_end ? '0 : tick_num;
      if (tick_num == TickLo)  votes_d[0] = rx_s2_q;
      if (tick_num == TickMid) votes_d[1] = rx_s2_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          clear         = 1'b1;
          smp_cnt_d     = '0;
          baud_d        = baud_select;
          parity_type_d = parity_type;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch: drop it without touching outputs.
        if (at_sample) begin
          if (!bit_val) busy_d = 1'b1;
          else          state_d = ST_IDLE;
        end else if (at_end) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_sample) begin
          shift_d = {bit_val, shift_q[7:1]};
        end else if (at_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (at_sample)   par_rx_d = bit_val;
        else if (at_end) state_d  = ST_STOP;
      end
      ST_STOP: begin
        if (at_sample) begin
          data_d  = shift_q;
          perr_d  = par_rx_q ^ (^shift_q) ^ parity_type_q;
          ferr_d  = ~bit_val;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = bit_val ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      parity_type_q <= 1'b0;
      smp_cnt_q     <= '0;
      votes_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_rx_q      <= 1'b0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
    end else begin
      rx_s1_q       <= rx_in;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      state_q       <= state_d;
      baud_q        <= baud_d;
      parity_type_q <= parity_type_d;
      smp_cnt_q     <= smp_cnt_d;
      votes_q       <= votes_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      par_rx_q      <= par_rx_d;
      data_q        <= data_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      perr_q        <= perr_d;
      ferr_q        <= ferr_d;
    end
  end

  assign rx_data_out   = data_q;
  assign rx_data_ready = ready_q;
  assign rx_busy       = busy_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: the driver serialises frames and queues the
// frame-level expected result; a monitor checks every rx_data_ready pulse against it.
module tb_uart_rx_oversample;

  // Low clock rate keeps frames short: divisors are 32, 16, 4, 2.
  localparam int unsigned CLK_HZ     = 614400;
  localparam int unsigned OS         = 16;
  localparam int unsigned PERIOD     = 10;
  localparam int unsigned GLITCH_CYC = 12;  // ~20 us at CLK_HZ

  typedef struct {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned lat_lo;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [1:0] baud_select;
  logic       parity_type;
  logic       rx_in;
  logic [7:0] rx_data_out;
  logic       rx_data_ready, rx_busy, parity_error, framing_error;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_sent   = 0;
  int unsigned n_ready  = 0;
  time         t_start  = 0;
  logic [7:0]  last_data = 8'h00;
  logic        last_perr = 1'b0;
  logic        last_ferr = 1'b0;

  always #(PERIOD / 2) sys_clk = ~sys_clk;

  uart_rx_oversample #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OS)
  ) dut (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .parity_type   (parity_type),
    .rx_in         (rx_in),
    .rx_data_out   (rx_data_out),
    .rx_data_ready (rx_data_ready),
    .rx_busy       (rx_busy),
    .parity_error  (parity_error),
    .framing_error (framing_error)
  );

  function automatic int unsigned div_of(input logic [1:0] sel);
    int unsigned baud;
    case (sel)
      2'b00:   baud = 1200;
      2'b01:   baud = 2400;
      2'b10:   baud = 9600;
      default: baud = 19200;
    endcase
    return (CLK_HZ + baud * OS / 2) / (baud * OS);
  endfunction

  function automatic logic good_parity(input logic [7:0] data, input logic ptype);
    return logic'(($countones(data) % 2) != 0) ^ ptype;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act,
                             input int unsigned lo, input int unsigned hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_held();
    check("held_data", rx_data_out, last_data);
    check("held_perr", parity_error, last_perr);
    check("held_ferr", framing_error, last_ferr);
    check("idle_busy", rx_busy, 0);
  endtask

  // Drives one 11-bit frame at the given rate; must be called just after a posedge.
  task automatic send_frame(input logic [1:0] sel, input logic ptype, input logic [7:0] data,
                            input logic par_bit, input logic stop_bit, input bit scramble);
    int unsigned div, bt;
    logic [10:0] bits;
    exp_t e;
    div  = div_of(sel);
    bt   = OS * div;
    bits = {stop_bit, par_bit, data, 1'b0};
    baud_select = sel;
    parity_type = ptype;
    e.data   = data;
    e.perr   = ((($countones(data) + int'(par_bit)) % 2) != int'(ptype));
    e.ferr   = !stop_bit;
    // Ready follows tick 9 of the stop bit (bit index 10) by one clock, plus sync delay.
    e.lat_lo = (10 * OS + 9) * div + 1;
    exp_q.push_back(e);
    n_sent++;
    for (int i = 0; i < 11; i++) begin
      rx_in = bits[i];
      if (i == 0) t_start = $time;
      if (i == 1 && scramble) begin
        baud_select = 2'($urandom);
        parity_type = 1'($urandom);
      end
      repeat (bt / 2) @(posedge sys_clk);
      @(negedge sys_clk);
      if (i == 3) check("busy_mid_frame", rx_busy, 1);
      repeat (bt - bt / 2) @(posedge sys_clk);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic        prev_ready;
    logic        prev_busy;
    int unsigned lat;
    prev_ready = 1'b0;
    prev_busy  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rx_data_ready === 1'b1) begin
        n_ready++;
        check("ready_one_cycle", prev_ready, 0);
        check("busy_before_ready", prev_busy, 1);
        check("busy_clear_at_ready", rx_busy, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got pulse with data 0x%0h, required no pulse",
                   rx_data_out);
        end else begin
          e   = exp_q.pop_front();
          lat = int'(($time - t_start) / PERIOD);
          check("rx_data_out", rx_data_out, e.data);
          check("parity_error", parity_error, e.perr);
          check("framing_error", framing_error, e.ferr);
          check_range("ready_latency", lat, e.lat_lo, e.lat_lo + 3);
          last_data = e.data;
          last_perr = e.perr;
          last_ferr = e.ferr;
        end
      end
      prev_ready = rx_data_ready;
      prev_busy  = rx_busy;
    end
  end

  initial begin : watchdog
    #(PERIOD * 90000);
    $display("FAIL watchdog: simulation still running after 90000 cycles, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic       busy_seen;
    logic [7:0] abort_byte;
    logic [1:0] sel;
    logic       ptype, par, stop, prev_bad;
    logic [7:0] data;

    reset       = 1'b0;
    rx_in       = 1'b1;
    baud_select = 2'b10;
    parity_type = 1'b0;
    idle(3);
    check("rst_data", rx_data_out, 0);
    check("rst_ready", rx_data_ready, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_perr", parity_error, 0);
    check("rst_ferr", framing_error, 0);
    reset = 1'b1;
    idle(20);

    // 9600 even, clean frame.
    send_frame(2'b10, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0);
    idle(16);
    check_held();

    // 9600 odd: 0x0F has even weight so odd parity wants 1; sending 0 must flag an error.
    send_frame(2'b10, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
    idle(16);
    check_held();

    // Short low pulse on an idle line is rejected by the start-bit vote.
    baud_select = 2'b10;
    rx_in = 1'b0;
    idle(GLITCH_CYC);
    rx_in = 1'b1;
    busy_seen = 1'b0;
    repeat (3 * OS * div_of(2'b10)) begin
      @(posedge sys_clk);
      #1;
      busy_seen |= rx_busy;
    end
    check("glitch_busy", busy_seen, 0);
    check_held();

    // 2400, stop bit low, line held low afterwards: no new frame until it goes high.
    send_frame(2'b01, 1'b0, 8'h55, good_parity(8'h55, 1'b0), 1'b0, 1'b0);
    busy_seen = 1'b0;
    repeat (2 * OS * div_of(2'b01)) begin
      @(posedge sys_clk);
      #1;
      busy_seen |= rx_busy;
    end
    check("wait_idle_busy", busy_seen, 0);
    rx_in = 1'b1;
    idle(OS * div_of(2'b01));
    check_held();

    // Reset in the middle of data bit 4 abandons the frame.
    abort_byte  = 8'hA5;
    baud_select = 2'b10;
    parity_type = 1'b0;
    rx_in = 1'b0;
    idle(OS * div_of(2'b10));
    for (int i = 0; i < 4; i++) begin
      rx_in = abort_byte[i];
      idle(OS * div_of(2'b10));
    end
    rx_in = abort_byte[4];
    idle(OS * div_of(2'b10) / 2);
    check("busy_before_abort", rx_busy, 1);
    reset = 1'b0;
    rx_in = 1'b1;
    idle(3);
    check("abort_data", rx_data_out, 0);
    check("abort_ready", rx_data_ready, 0);
    check("abort_busy", rx_busy, 0);
    check("abort_perr", parity_error, 0);
    check("abort_ferr", framing_error, 0);
    last_data = 8'h00;
    last_perr = 1'b0;
    last_ferr = 1'b0;
    reset = 1'b1;
    idle(OS * div_of(2'b10));
    check_held();
    send_frame(2'b10, 1'b0, 8'h3C, good_parity(8'h3C, 1'b0), 1'b1, 1'b0);

    // 19200 back-to-back frames with no idle gap.
    send_frame(2'b11, 1'b0, 8'h00, good_parity(8'h00, 1'b0), 1'b1, 1'b0);
    send_frame(2'b11, 1'b0, 8'hFF, good_parity(8'hFF, 1'b0), 1'b1, 1'b0);
    send_frame(2'b11, 1'b0, 8'h81, good_parity(8'h81, 1'b0), 1'b1, 1'b0);
    idle(8);
    check_held();

    // Random frames; settings on the input pins are scrambled mid-frame.
    prev_bad = 1'b0;
    for (int it = 0; it < 16; it++) begin
      sel   = (it == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      ptype = 1'($urandom);
      data  = 8'($urandom);
      par   = good_parity(data, ptype) ^ ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 5) != 0);
      if (prev_bad || $urandom_range(0, 2) != 0) begin
        rx_in = 1'b1;
        idle($urandom_range(4, 40));
        check_held();
      end
      send_frame(sel, ptype, data, par, stop, 1'b1);
      prev_bad = !stop;
    end
    rx_in = 1'b1;

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge sys_clk);
    idle(20);
    check("queue_drained", exp_q.size(), 0);
    check("ready_count", n_ready, n_sent);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
